// File: rtl/goods_key_entry.sv
// goods_key_entry: debounces the 16 front-panel keys and builds a goods selection
// (high code, low code, quantity) handed over on sel_valid/sel_ack. Optional idle abort: ENTRY_TIMEOUT_EN.
module goods_key_entry #(
    parameter logic [24:0] SAMPLE_DIV  = 25'd499_999,
    parameter int          DEB_LEN     = 3,
    parameter logic [11:0] TIMEOUT_SMP = 12'd3000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] key_raw,
    input  logic        sel_ack,
    output logic [15:0] key_level,
    output logic [15:0] key_pulse,
    output logic [2:0]  goods_high,
    output logic [2:0]  goods_low,
    output logic [1:0]  goods_num,
    output logic        sel_valid,
    output logic [2:0]  entry_phase,
    output logic        entry_err
);

    typedef enum logic [2:0] {
        PH_HIGH    = 3'd0,
        PH_LOW     = 3'd1,
        PH_NUM     = 3'd2,
        PH_CONFIRM = 3'd3,
        PH_VALID   = 3'd4
    } phase_e;

    localparam logic [3:0] KEY_CLEAR   = 4'd14;
    localparam logic [3:0] KEY_CONFIRM = 4'd15;

    logic [15:0]               sync1_q, sync2_q;
    logic [24:0]               div_cnt_q;
    logic                      tick;
    logic [15:0][DEB_LEN-1:0]  hist_q, hist_d;
    logic [15:0]               level_q, level_d, level_dly_q, pulse_q;

    phase_e      phase_q;
    logic [2:0]  high_q, low_q;
    logic [1:0]  num_q;
    logic        valid_q, err_q;

    logic [3:0]  key_idx;
    logic        single, is_digit, is_qty, is_clear, is_confirm;
    logic        ev_digit_ok, ev_qty_ok, ev_conf_ok, ev_clear_ok, accept, key_bad;
    logic        timeout_hit;

    assign tick = (div_cnt_q == SAMPLE_DIV - 25'd1);

    // Two-flop synchroniser for the asynchronous key inputs, plus the sample divider.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            div_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values;
            // a blocking = here would collapse the two synchroniser stages into one.
            sync1_q   <= key_raw;
            sync2_q   <= sync1_q;
            div_cnt_q <= tick ? '0 : div_cnt_q + 25'd1;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise paths that
        // skip the assignment (no tick) would infer latches.
        hist_d  = hist_q;
        level_d = level_q;
        if (tick) begin
            for (int i = 0; i < 16; i++) begin
                hist_d[i] = {hist_q[i][DEB_LEN-2:0], sync2_q[i]};
                if (&hist_d[i]) begin
                    level_d[i] = 1'b1;
                end else if (~|hist_d[i]) begin
                    level_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            // NOTE: the sample history is a small flop array, not a RAM, so it is reset
            // like any register; an unreset history could fire a pulse after reset.
            hist_q      <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            pulse_q     <= '0;
        end else begin
            hist_q      <= hist_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            pulse_q     <= level_q & ~level_dly_q;
        end
    end

    // Event decode: only a single-bit pulse is a key event; several bits at once is an error.
    always_comb begin
        key_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (pulse_q[i]) key_idx = 4'(i);
        end
        single      = $onehot(pulse_q);
        is_digit    = single && !key_idx[3];
        is_qty      = single && (key_idx inside {4'd8, 4'd9, 4'd10});
        is_clear    = single && (key_idx == KEY_CLEAR);
        is_confirm  = single && (key_idx == KEY_CONFIRM);
        ev_digit_ok = is_digit && (phase_q == PH_HIGH || phase_q == PH_LOW);
        ev_qty_ok   = is_qty && (phase_q == PH_NUM);
        ev_conf_ok  = is_confirm && (phase_q == PH_CONFIRM);
        ev_clear_ok = is_clear && (phase_q != PH_VALID);
        accept      = ev_digit_ok || ev_qty_ok || ev_conf_ok || ev_clear_ok;
        key_bad     = (|pulse_q) && (phase_q != PH_VALID) && !accept;
    end

`ifdef ENTRY_TIMEOUT_EN
    logic [11:0] idle_q;
    logic        in_entry;

    assign in_entry    = (phase_q == PH_LOW) || (phase_q == PH_NUM) || (phase_q == PH_CONFIRM);
    assign timeout_hit = in_entry && (idle_q == TIMEOUT_SMP);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idle_q <= '0;
        end else if (!in_entry || accept || timeout_hit) begin
            idle_q <= '0;
        end else if (tick) begin
            idle_q <= idle_q + 12'd1;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT_SMP;
`endif

    // Entry FSM; an abort (timeout or CLEAR) takes precedence over the phase logic.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase_q <= PH_HIGH;
            high_q  <= '0;
            low_q   <= '0;
            num_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (timeout_hit) begin
                phase_q <= PH_HIGH;
                high_q  <= '0;
                low_q   <= '0;
                num_q   <= '0;
                err_q   <= 1'b1;
            end else if (ev_clear_ok) begin
                phase_q <= PH_HIGH;
                high_q  <= '0;
                low_q   <= '0;
                num_q   <= '0;
            end else begin
                case (phase_q)
                    PH_HIGH: begin
                        if (is_digit) begin
                            high_q  <= key_idx[2:0];
                            phase_q <= PH_LOW;
                        end
                    end
                    PH_LOW: begin
                        if (is_digit) begin
                            low_q   <= key_idx[2:0];
                            phase_q <= PH_NUM;
                        end
                    end
                    PH_NUM: begin
                        if (is_qty) begin
                            num_q   <= key_idx[1:0] + 2'd1;
                            phase_q <= PH_CONFIRM;
                        end
                    end
                    PH_CONFIRM: begin
                        if (is_confirm) begin
                            valid_q <= 1'b1;
                            phase_q <= PH_VALID;
                        end
                    end
                    PH_VALID: begin
                        // Keys are ignored here, so an ack in the same cycle as a key wins.
                        if (sel_ack) begin
                            valid_q <= 1'b0;
                            high_q  <= '0;
                            low_q   <= '0;
                            num_q   <= '0;
                            phase_q <= PH_HIGH;
                        end
                    end
                    default: phase_q <= PH_HIGH;
                endcase
                if (key_bad) err_q <= 1'b1;
            end
        end
    end

    assign key_level   = level_q;
    assign key_pulse   = pulse_q;
    assign goods_high  = high_q;
    assign goods_low   = low_q;
    assign goods_num   = num_q;
    assign sel_valid   = valid_q;
    assign entry_phase = phase_q;
    assign entry_err   = err_q;

endmodule

// File: tb/tb_goods_key_entry.sv
// Self-checking bench for goods_key_entry: table of key presses with expected entry state,
// routed through a scoreboard queue, plus hand-written reset/bounce/handshake/timeout sequences.
module tb_goods_key_entry;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] key_raw = '0;
    logic        sel_ack = 1'b0;
    logic [15:0] key_level, key_pulse;
    logic [2:0]  goods_high, goods_low, entry_phase;
    logic [1:0]  goods_num;
    logic        sel_valid, entry_err;

    always #5 sys_clk = ~sys_clk;

    goods_key_entry #(
        .SAMPLE_DIV (25'd4),
        .DEB_LEN    (3),
        .TIMEOUT_SMP(12'd20)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_raw    (key_raw),
        .sel_ack    (sel_ack),
        .key_level  (key_level),
        .key_pulse  (key_pulse),
        .goods_high (goods_high),
        .goods_low  (goods_low),
        .goods_num  (goods_num),
        .sel_valid  (sel_valid),
        .entry_phase(entry_phase),
        .entry_err  (entry_err)
    );

    typedef struct {
        logic [15:0] keys;
        logic [2:0]  phase;
        logic [2:0]  high;
        logic [2:0]  low;
        logic [1:0]  num;
        logic        valid;
        int          errs;
    } vec_t;

    vec_t vecs[19];
    vec_t sb_q[$];

    int   tests = 0;
    int   fails = 0;
    int   err_cnt = 0;
    int   pulse3_cnt = 0;
    int   rise3_cnt = 0;
    logic lvl3_prev = 1'b0;

    always @(negedge sys_clk) begin
        if (entry_err) err_cnt++;
        if (key_pulse[3]) pulse3_cnt++;
        if (key_level[3] && !lvl3_prev) rise3_cnt++;
        lvl3_prev = key_level[3];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_level(input logic [15:0] want, input string name, output int cyc);
        bit ok = 1'b0;
        cyc = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge sys_clk);
            cyc++;
            if (key_level == want) ok = 1'b1;
        end
        check(name, ok, 1'b1);
    endtask

    task automatic apply(input int idx);
        vec_t exp;
        int   e0, cyc;
        bit   seen = 1'b0;
        sb_q.push_back(vecs[idx]);
        e0 = err_cnt;
        key_raw = vecs[idx].keys;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge sys_clk);
            if (key_pulse != '0) seen = 1'b1;
        end
        check($sformatf("v%0d_pulse_seen", idx), seen, 1'b1);
        wait_cycles(3);
        exp = sb_q.pop_front();
        check($sformatf("v%0d_phase", idx), entry_phase, exp.phase);
        check($sformatf("v%0d_high", idx), goods_high, exp.high);
        check($sformatf("v%0d_low", idx), goods_low, exp.low);
        check($sformatf("v%0d_num", idx), goods_num, exp.num);
        check($sformatf("v%0d_valid", idx), sel_valid, exp.valid);
        check($sformatf("v%0d_errs", idx), err_cnt - e0, exp.errs);
        key_raw = '0;
        wait_level('0, $sformatf("v%0d_release", idx), cyc);
        wait_cycles(1);
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) apply(i);
    endtask

    initial begin
        int cyc, p0, r0, e0;

        //           keys      phase high  low   num   valid errs
        vecs[0]  = '{16'h4000, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 0};
        vecs[1]  = '{16'h0006, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1};
        vecs[2]  = '{16'h8000, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1};
        vecs[3]  = '{16'h0800, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1};
        vecs[4]  = '{16'h0020, 3'd1, 3'd5, 3'd0, 2'd0, 1'b0, 0};
        vecs[5]  = '{16'h0004, 3'd2, 3'd5, 3'd2, 2'd0, 1'b0, 0};
        vecs[6]  = '{16'h0008, 3'd2, 3'd5, 3'd2, 2'd0, 1'b0, 1};
        vecs[7]  = '{16'h0200, 3'd3, 3'd5, 3'd2, 2'd2, 1'b0, 0};
        vecs[8]  = '{16'h8000, 3'd4, 3'd5, 3'd2, 2'd2, 1'b1, 0};
        vecs[9]  = '{16'h0001, 3'd4, 3'd5, 3'd2, 2'd2, 1'b1, 0};
        vecs[10] = '{16'h0040, 3'd1, 3'd6, 3'd0, 2'd0, 1'b0, 0};
        vecs[11] = '{16'h0010, 3'd2, 3'd6, 3'd4, 2'd0, 1'b0, 0};
        vecs[12] = '{16'h4000, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 0};
        vecs[13] = '{16'h0080, 3'd1, 3'd7, 3'd0, 2'd0, 1'b0, 0};
        vecs[14] = '{16'h4000, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 0};
        vecs[15] = '{16'h0020, 3'd1, 3'd5, 3'd0, 2'd0, 1'b0, 0};
        vecs[16] = '{16'h0004, 3'd2, 3'd5, 3'd2, 2'd0, 1'b0, 0};
        vecs[17] = '{16'h0400, 3'd3, 3'd5, 3'd2, 2'd3, 1'b0, 0};
        vecs[18] = '{16'h8000, 3'd4, 3'd5, 3'd2, 2'd3, 1'b1, 0};

        // Reset held with every key pressed: all outputs stay at zero.
        key_raw = 16'hFFFF;
        wait_cycles(6);
        check("rst_outputs", {key_level, key_pulse, goods_high, goods_low, goods_num,
                              sel_valid, entry_phase, entry_err}, 64'd0);
        sys_rst_n = 1'b1;
        wait_level(16'hFFFF, "rst_level_set", cyc);
        check("rst_level_after_3_ticks", (cyc >= 9 && cyc <= 16), 1'b1);
        wait_cycles(3);
        check("rst_multi_err", err_cnt, 1);
        check("rst_phase", entry_phase, 3'd0);
        key_raw = '0;
        wait_level('0, "rst_release", cyc);

        // Bouncing key 3 never holds three equal samples; then held -> one clean press.
        p0 = pulse3_cnt;
        r0 = rise3_cnt;
        for (int t = 0; t < 12; t++) begin
            key_raw[3] = ~key_raw[3];
            wait_cycles(5);
        end
        key_raw[3] = 1'b1;
        wait_level(16'h0008, "bounce_level", cyc);
        wait_cycles(4);
        check("bounce_pulses", pulse3_cnt - p0, 1);
        check("bounce_rises", rise3_cnt - r0, 1);
        check("bounce_phase", entry_phase, 3'd1);
        check("bounce_high", goods_high, 3'd3);
        key_raw = '0;
        wait_level('0, "bounce_release", cyc);

        // Clear, error cases, then a full entry up to VALID.
        run_range(0, 9);

        // Handshake: a single-cycle ack returns everything to the idle state.
        sel_ack = 1'b1;
        wait_cycles(1);
        sel_ack = 1'b0;
        check("ack_valid", sel_valid, 1'b0);
        check("ack_goods", {goods_high, goods_low, goods_num}, 8'd0);
        check("ack_phase", entry_phase, 3'd0);

        // An ack outside VALID changes nothing.
        run_range(10, 10);
        sel_ack = 1'b1;
        wait_cycles(1);
        sel_ack = 1'b0;
        wait_cycles(1);
        check("stray_ack_phase", entry_phase, 3'd1);
        check("stray_ack_high", goods_high, 3'd6);
        run_range(11, 13);

        // Idle after a partial entry.
        e0 = err_cnt;
        wait_cycles(120);
`ifdef ENTRY_TIMEOUT_EN
        check("timeout_phase", entry_phase, 3'd0);
        check("timeout_high", goods_high, 3'd0);
        check("timeout_err", err_cnt - e0, 1);
`else
        check("no_timeout_phase", entry_phase, 3'd1);
        check("no_timeout_high", goods_high, 3'd7);
        check("no_timeout_err", err_cnt - e0, 0);
`endif
        run_range(14, 18);

        // Asynchronous reset between clock edges drops sel_valid immediately.
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst_valid", sel_valid, 1'b0);
        check("async_rst_state", {entry_phase, goods_high, goods_low, goods_num}, 11'd0);
        wait_cycles(2);
        sys_rst_n = 1'b1;
        wait_cycles(4);
        check("post_rst_phase", entry_phase, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, limit 2000000 reached");
        $fatal(1, "time limit");
    end

endmodule
